minimig_sram_arbiter: RTL and testbench



---
 rtl/minimig_sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_minimig_sram_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minimig_sram_arbiter.sv
// minimig_sram_arbiter: shares one asynchronous SRAM between the chipset DMA
// path and the 68000 bus interface. DMA has priority, but the CPU is granted
// after two consecutive DMA grants taken while it was waiting. Every access is
// IDLE -> SETUP -> STROBE1 -> STROBE2 -> DONE. All SRAM strobes are registered
// from the next state, so they switch cleanly on clock edges.
module minimig_sram_arbiter (
    input  logic        c_28m,
    input  logic        _reset,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [20:1] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [20:1] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_ub,
    input  logic        cpu_lb,
    output logic        cpu_ack,
    output logic [15:0] rd_data,
    input  logic [15:0] ramdata_in,
    output logic [15:0] ramdata_out,
    output logic        ramdata_oe,
    output logic [19:1] ramaddress,
    output logic        _ramsel0,
    output logic        _ramsel1,
    output logic        _ub,
    output logic        _lb,
    output logic        _we,
    output logic        _oe
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE1 = 3'd2,
        STROBE2 = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        grant_s;
    logic        grant_cpu_s;
    logic [1:0]  streak_r;
    logic        cur_cpu_r;
    logic        cur_wr_r;
    logic        cur_ub_r;
    logic        cur_lb_r;
    logic        cur_bank_r;
    logic [20:1] grant_addr_s;
    logic [15:0] grant_wdata_s;
    logic        sel_cpu_s;
    logic        sel_wr_s;
    logic        sel_ub_s;
    logic        sel_lb_s;
    logic        sel_bank_s;
    logic        in_access_s;
    logic        in_strobe_s;
    logic        in_cycle_s;

    // Next-state logic and arbitration; requests are only looked at in IDLE.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        grant_cpu_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (dma_req || cpu_req) begin
                    grant_s      = 1'b1;
                    grant_cpu_s  = cpu_req && (!dma_req || (streak_r == 2'd2));
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP:   next_state_s = STROBE1;
            STROBE1: next_state_s = STROBE2;
            STROBE2: next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Access attributes: the winner's inputs on the grant edge, latched copies afterwards.
    always_comb begin
        grant_addr_s  = grant_cpu_s ? cpu_addr : dma_addr;
        grant_wdata_s = grant_cpu_s ? cpu_wdata : dma_wdata;
        if (grant_s) begin
            sel_cpu_s  = grant_cpu_s;
            sel_wr_s   = grant_cpu_s ? cpu_wr : dma_wr;
            sel_ub_s   = grant_cpu_s ? cpu_ub : 1'b1;
            sel_lb_s   = grant_cpu_s ? cpu_lb : 1'b1;
            sel_bank_s = grant_addr_s[20];
        end else begin
            sel_cpu_s  = cur_cpu_r;
            sel_wr_s   = cur_wr_r;
            sel_ub_s   = cur_ub_r;
            sel_lb_s   = cur_lb_r;
            sel_bank_s = cur_bank_r;
        end
        in_access_s = (next_state_s == SETUP) || (next_state_s == STROBE1) ||
                      (next_state_s == STROBE2);
        in_strobe_s = (next_state_s == STROBE1) || (next_state_s == STROBE2);
        in_cycle_s  = in_access_s || (next_state_s == DONE);
    end

    // State, latched request fields, streak counter and registered SRAM/ack outputs.
    always_ff @(posedge c_28m or negedge _reset) begin
        if (!_reset) begin
            state_r     <= IDLE;
            streak_r    <= 2'd0;
            cur_cpu_r   <= 1'b0;
            cur_wr_r    <= 1'b0;
            cur_ub_r    <= 1'b0;
            cur_lb_r    <= 1'b0;
            cur_bank_r  <= 1'b0;
            ramaddress  <= 19'd0;
            ramdata_out <= 16'd0;
            ramdata_oe  <= 1'b0;
            _ramsel0    <= 1'b1;
            _ramsel1    <= 1'b1;
            _ub         <= 1'b1;
            _lb         <= 1'b1;
            _we         <= 1'b1;
            _oe         <= 1'b1;
            dma_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            rd_data     <= 16'd0;
        end else begin
            state_r <= next_state_s;
            if (grant_s) begin
                cur_cpu_r   <= sel_cpu_s;
                cur_wr_r    <= sel_wr_s;
                cur_ub_r    <= sel_ub_s;
                cur_lb_r    <= sel_lb_s;
                cur_bank_r  <= sel_bank_s;
                ramaddress  <= grant_addr_s[19:1];
                ramdata_out <= grant_wdata_s;
                if (grant_cpu_s) begin
                    streak_r <= 2'd0;
                end else if (cpu_req) begin
                    streak_r <= (streak_r == 2'd2) ? 2'd2 : streak_r + 2'd1;
                end else begin
                    streak_r <= 2'd0;
                end
            end
            _ramsel0   <= ~(in_access_s && !sel_bank_s);
            _ramsel1   <= ~(in_access_s && sel_bank_s);
            _ub        <= ~(in_access_s && sel_ub_s);
            _lb        <= ~(in_access_s && sel_lb_s);
            _oe        <= ~(in_access_s && !sel_wr_s);
            _we        <= ~(in_strobe_s && sel_wr_s);
            ramdata_oe <= in_cycle_s && sel_wr_s;
            dma_ack    <= (next_state_s == DONE) && !sel_cpu_s;
            cpu_ack    <= (next_state_s == DONE) && sel_cpu_s;
            if ((state_r == STROBE2) && !cur_wr_r) begin
                rd_data <= ramdata_in;
            end
        end
    end

endmodule

// File: tb/tb_minimig_sram_arbiter.sv
// Directed testbench for minimig_sram_arbiter with a small two-bank SRAM model.
module tb_minimig_sram_arbiter;

    logic        c_28m = 1'b0;
    logic        _reset;
    logic        dma_req, dma_wr;
    logic [20:1] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic        cpu_req, cpu_wr;
    logic [20:1] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ub, cpu_lb;
    logic        cpu_ack;
    logic [15:0] rd_data;
    logic [15:0] ramdata_in;
    logic [15:0] ramdata_out;
    logic        ramdata_oe;
    logic [19:1] ramaddress;
    logic        _ramsel0, _ramsel1, _ub, _lb, _we, _oe;

    int passed = 0;
    int total  = 0;
    int cycle  = 0;
    int viol   = 0;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    minimig_sram_arbiter dut (
        .c_28m(c_28m), ._reset(_reset),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ub(cpu_ub), .cpu_lb(cpu_lb),
        .cpu_ack(cpu_ack), .rd_data(rd_data),
        .ramdata_in(ramdata_in), .ramdata_out(ramdata_out),
        .ramdata_oe(ramdata_oe), .ramaddress(ramaddress),
        ._ramsel0(_ramsel0), ._ramsel1(_ramsel1),
        ._ub(_ub), ._lb(_lb), ._we(_we), ._oe(_oe)
    );

    // 28 MHz clock stand-in.
    always #5 c_28m = ~c_28m;

    // Cycle counter used to measure grant spacing.
    always @(posedge c_28m) cycle <= cycle + 1;

    // SRAM model: byte-lane writes while _we is low on a selected bank.
    always @(posedge c_28m) begin
        if (!_we && !_ramsel0) begin
            if (!_ub) mem0[ramaddress[8:1]][15:8] <= ramdata_out[15:8];
            if (!_lb) mem0[ramaddress[8:1]][7:0]  <= ramdata_out[7:0];
        end
        if (!_we && !_ramsel1) begin
            if (!_ub) mem1[ramaddress[8:1]][15:8] <= ramdata_out[15:8];
            if (!_lb) mem1[ramaddress[8:1]][7:0]  <= ramdata_out[7:0];
        end
    end

    assign ramdata_in = !_oe ? (!_ramsel1 ? mem1[ramaddress[8:1]] : mem0[ramaddress[8:1]])
                             : 16'h0000;

    // Exclusivity monitor.
    always @(negedge c_28m) begin
        if (!_we && !_oe) viol <= viol + 1;
        if (dma_ack && cpu_ack) viol <= viol + 1;
        if (!_ramsel0 && !_ramsel1) viol <= viol + 1;
    end

    function automatic logic [8:0] strobes();
        return {_ramsel0, _ramsel1, _ub, _lb, _we, _oe, ramdata_oe, dma_ack, cpu_ack};
    endfunction

    // Waits (at negedges) for any ack; who = 1 DMA, 2 CPU, 3 both, 0 timeout.
    task automatic wait_ack(input int budget, output int who, output int cyc);
        who = 0;
        cyc = 0;
        for (int t = 0; t < budget; t++) begin
            @(posedge c_28m);
            @(negedge c_28m);
            if (dma_ack || cpu_ack) begin
                who = (dma_ack ? 1 : 0) + (cpu_ack ? 2 : 0);
                cyc = cycle;
                return;
            end
        end
    endtask

    // One isolated access; called at a negedge with the DUT idle.
    task automatic do_access(input logic is_cpu, input logic wr, input logic [20:1] addr,
                             input logic [15:0] data, input logic ub, input logic lb,
                             output int who);
        int c;
        if (is_cpu) begin
            cpu_wr = wr; cpu_addr = addr; cpu_wdata = data; cpu_ub = ub; cpu_lb = lb;
            cpu_req = 1'b1;
        end else begin
            dma_wr = wr; dma_addr = addr; dma_wdata = data;
            dma_req = 1'b1;
        end
        wait_ack(20, who, c);
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic test_reset();
        _reset = 1'b0;
        #12;
        total++;
        if ({strobes(), ramaddress, ramdata_out, rd_data} !== {9'b111111000, 19'd0, 16'd0, 16'd0})
            $display("FAIL reset_state: got %b/%h/%h/%h want 111111000/0/0/0",
                     strobes(), ramaddress, ramdata_out, rd_data);
        else passed++;
        @(negedge c_28m);
        _reset = 1'b1;
        @(negedge c_28m);
    endtask

    task automatic test_cpu_write();
        logic [8:0] exp;
        cpu_wr = 1'b1; cpu_addr = 20'h00010; cpu_wdata = 16'hA55A; cpu_ub = 1'b1; cpu_lb = 1'b0;
        cpu_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge c_28m);
            @(negedge c_28m);
            if (i <= 3)      exp = {1'b0, 1'b1, 1'b0, 1'b1, (i >= 2) ? 1'b0 : 1'b1, 1'b1, 1'b1, 2'b00};
            else if (i == 4) exp = 9'b111111101;
            else             exp = 9'b111111000;
            total++;
            if (strobes() !== exp)
                $display("FAIL cpu_write_cycle%0d: got %b want %b", i, strobes(), exp);
            else passed++;
            if (i <= 4) begin
                total++;
                if ({ramaddress, ramdata_out} !== {19'h00010, 16'hA55A})
                    $display("FAIL cpu_write_bus%0d: got %h/%h want 00010/a55a", i, ramaddress, ramdata_out);
                else passed++;
            end
            if (i == 4) cpu_req = 1'b0;
        end
        total++;
        if (mem0[8'h10][15:8] !== 8'hA5)
            $display("FAIL cpu_write_mem: got %h want a5", mem0[8'h10][15:8]);
        else passed++;
    endtask

    task automatic test_dma_read();
        logic [8:0] exp;
        int who;
        do_access(1'b0, 1'b1, 20'h80020, 16'h1234, 1'b1, 1'b1, who);
        @(negedge c_28m);
        dma_wr = 1'b0; dma_addr = 20'h80020; dma_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge c_28m);
            @(negedge c_28m);
            if (i <= 3)      exp = 9'b100010000;
            else if (i == 4) exp = 9'b111111010;
            else             exp = 9'b111111000;
            total++;
            if (strobes() !== exp)
                $display("FAIL dma_read_cycle%0d: got %b want %b", i, strobes(), exp);
            else passed++;
            if (i == 1) begin
                total++;
                if (ramaddress !== 19'h00020)
                    $display("FAIL dma_read_addr: got %h want 00020", ramaddress);
                else passed++;
            end
            if (i == 4) begin
                total++;
                if (rd_data !== 16'h1234)
                    $display("FAIL dma_read_data: got %h want 1234", rd_data);
                else passed++;
                dma_req = 1'b0;
            end
        end
        do_access(1'b1, 1'b1, 20'h00040, 16'h5678, 1'b1, 1'b1, who);
        @(negedge c_28m);
        total++;
        if (rd_data !== 16'h1234 || who !== 2)
            $display("FAIL rd_data_hold: got %h ack %0d want 1234 ack 2", rd_data, who);
        else passed++;
    endtask

    task automatic test_contention();
        int order [6] = '{1, 1, 2, 1, 1, 2};
        int who, c, prev;
        prev = 0;
        dma_wr = 1'b0; dma_addr = 20'h00001;
        cpu_wr = 1'b0; cpu_addr = 20'h00002; cpu_ub = 1'b1; cpu_lb = 1'b1;
        dma_req = 1'b1; cpu_req = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wait_ack(12, who, c);
            total++;
            if (who !== order[n])
                $display("FAIL contention_order%0d: got %0d want %0d", n, who, order[n]);
            else passed++;
            if (n > 0) begin
                total++;
                if (c - prev !== 5)
                    $display("FAIL contention_spacing%0d: got %0d want 5", n, c - prev);
                else passed++;
            end
            prev = c;
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        @(negedge c_28m);
    endtask

    task automatic test_zero_be();
        logic [8:0] exp;
        int who;
        do_access(1'b1, 1'b1, 20'h00030, 16'hBEEF, 1'b1, 1'b1, who);
        @(negedge c_28m);
        cpu_wr = 1'b1; cpu_addr = 20'h00030; cpu_wdata = 16'h0000; cpu_ub = 1'b0; cpu_lb = 1'b0;
        cpu_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge c_28m);
            @(negedge c_28m);
            exp = {_ub, _lb, cpu_ack};
            total++;
            if ({_ub, _lb, cpu_ack} !== {2'b11, (i == 4) ? 1'b1 : 1'b0})
                $display("FAIL zero_be_cycle%0d: got ub/lb/ack %b want 11%0d", i, exp[2:0], (i == 4) ? 1 : 0);
            else passed++;
            if (i == 4) cpu_req = 1'b0;
        end
        total++;
        if (mem0[8'h30] !== 16'hBEEF)
            $display("FAIL zero_be_mem: got %h want beef", mem0[8'h30]);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        int who, c, acks;
        int order [3] = '{1, 1, 2};
        dma_wr = 1'b0; dma_addr = 20'h00005;
        cpu_wr = 1'b1; cpu_addr = 20'h00050; cpu_wdata = 16'hCAFE; cpu_ub = 1'b1; cpu_lb = 1'b1;
        dma_req = 1'b1; cpu_req = 1'b1;
        wait_ack(12, who, c);
        wait_ack(12, who, c);
        @(posedge c_28m);
        @(posedge c_28m);
        @(posedge c_28m);
        #2;
        total++;
        if ({_we, ramdata_oe} !== 2'b01)
            $display("FAIL reset_mid_pre: got we/rdoe %b want 01", {_we, ramdata_oe});
        else passed++;
        _reset = 1'b0;
        #1;
        total++;
        if ({strobes(), ramaddress, ramdata_out} !== {9'b111111000, 19'd0, 16'd0})
            $display("FAIL reset_mid_async: got %b/%h/%h want 111111000/0/0",
                     strobes(), ramaddress, ramdata_out);
        else passed++;
        acks = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge c_28m);
            if (dma_ack || cpu_ack) acks++;
        end
        _reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_ack(12, who, c);
            if (dma_ack || cpu_ack) acks = acks + 0;
            total++;
            if (who !== order[n])
                $display("FAIL reset_regrant%0d: got %0d want %0d", n, who, order[n]);
            else passed++;
        end
        total++;
        if (acks !== 0)
            $display("FAIL reset_no_ack: got %0d acks want 0", acks);
        else passed++;
        dma_req = 1'b0; cpu_req = 1'b0;
        @(negedge c_28m);
    endtask

    task automatic test_streak_clear();
        int who, c;
        int order [3] = '{1, 1, 2};
        dma_wr = 1'b0; dma_addr = 20'h00007;
        cpu_wr = 1'b0; cpu_addr = 20'h00008; cpu_ub = 1'b1; cpu_lb = 1'b1;
        dma_req = 1'b1; cpu_req = 1'b1;
        wait_ack(12, who, c);
        cpu_req = 1'b0;
        wait_ack(12, who, c);
        total++;
        if (who !== 1)
            $display("FAIL streak_lone_dma: got %0d want 1", who);
        else passed++;
        cpu_req = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_ack(12, who, c);
            total++;
            if (who !== order[n])
                $display("FAIL streak_clear%0d: got %0d want %0d", n, who, order[n]);
            else passed++;
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        @(negedge c_28m);
    endtask

    task automatic test_exclusive();
        @(negedge c_28m);
        total++;
        if (viol !== 0)
            $display("FAIL exclusivity: got %0d violations want 0", viol);
        else passed++;
    endtask

    initial begin
        dma_req = 1'b0; dma_wr = 1'b0; dma_addr = 20'd0; dma_wdata = 16'd0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 20'd0; cpu_wdata = 16'd0;
        cpu_ub = 1'b0; cpu_lb = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        test_reset();
        test_cpu_write();
        test_dma_read();
        test_contention();
        test_zero_be();
        test_reset_mid_access();
        test_streak_clear();
        test_exclusive();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
